cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the single-cycle RISC-V core. It replaces the free-running divided clock with an explicit FETCH/DECODE/EXECUTE/MEM/WB state machine that waits out the fixed read latency of the instruction and data BRAMs. It owns the program counter and gates the register-file and data-memory write enables. It also provides run/step/halt debug control plus cycle and retired-instruction counters.

---
 rtl/cpu_sequencer.sv | 108 ++++++++++
 tb/tb_cpu_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for the RISC-V core.
// Owns the PC, gates RF/DMEM write enables, provides run/step/halt and counters.
module cpu_sequencer #(
  parameter int unsigned  IMEM_LATENCY = 2,
  parameter int unsigned  DMEM_LATENCY = 2,
  parameter logic [31:0]  PC_RESET     = 32'h0000_0000
) (
  input  logic        clk_100mhz,
  input  logic        rst_n_in,
  input  logic        run_in,
  input  logic        step_in,
  input  logic        halt_in,
  input  logic        is_load_in,
  input  logic        is_store_in,
  input  logic        wb_en_in,
  input  logic [31:0] next_pc_in,
  output logic [31:0] pc_out,
  output logic        inst_latch_out,
  output logic        rf_we_out,
  output logic        dmem_we_out,
  output logic [2:0]  state_out,
  output logic        retire_out,
  output logic        halted_out,
  output logic [31:0] cycle_count_out,
  output logic [31:0] instret_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    MEM     = 3'd4,
    WB      = 3'd5
  } state_t;

  localparam logic [2:0] FETCH_WAIT = 3'(IMEM_LATENCY);
  localparam logic [2:0] LOAD_WAIT  = 3'(DMEM_LATENCY);

  state_t      state, next_state;
  logic [2:0]  wait_cnt, next_wait;
  logic        mem_load;
  logic        one_shot;
  logic [31:0] pc;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!halt_in && (run_in || step_in)) next_state = FETCH;
      FETCH:   if (wait_cnt == 3'd0) next_state = DECODE;
      DECODE:  next_state = EXECUTE;
      EXECUTE: next_state = (is_load_in || is_store_in) ? MEM : WB;
      MEM:     if (wait_cnt == 3'd0) next_state = WB;
      WB:      next_state = (halt_in || one_shot || !run_in) ? IDLE : FETCH;
      default: next_state = IDLE;
    endcase
  end

  // Counter reloads on every state change so each visit sees the full latency.
  always_comb begin
    next_wait = '0;
    if (next_state != state) begin
      case (next_state)
        FETCH:   next_wait = FETCH_WAIT;
        MEM:     next_wait = is_load_in ? LOAD_WAIT : 3'd0;
        default: next_wait = '0;
      endcase
    end else if (wait_cnt != 3'd0) begin
      next_wait = wait_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      mem_load    <= 1'b0;
      one_shot    <= 1'b0;
      pc          <= PC_RESET;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_wait;
      if (state != IDLE) cycle_cnt <= cycle_cnt + 32'd1;
      if (state == EXECUTE) mem_load <= is_load_in;
      if (state == IDLE && next_state == FETCH && step_in) one_shot <= 1'b1;
      if (state == WB) begin
        one_shot    <= 1'b0;
        pc          <= next_pc_in;
        instret_cnt <= instret_cnt + 32'd1;
      end
    end
  end

  assign pc_out          = pc;
  assign inst_latch_out  = (state == FETCH) && (wait_cnt == 3'd0);
  assign rf_we_out       = (state == WB) && wb_en_in;
  assign dmem_we_out     = (state == MEM) && !mem_load;
  assign state_out       = state;
  assign retire_out      = (state == WB);
  assign halted_out      = (state == IDLE);
  assign cycle_count_out = cycle_cnt;
  assign instret_out     = instret_cnt;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed instructions push expected retire
// records; a negedge monitor pops and checks each retirement.
module tb_cpu_sequencer;

  logic        clk_100mhz = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        run_in = 1'b0, step_in = 1'b0, halt_in = 1'b0;
  logic        is_load_in = 1'b0, is_store_in = 1'b0, wb_en_in = 1'b0;
  logic [31:0] next_pc_in = '0;
  logic [31:0] pc_out, cycle_count_out, instret_out;
  logic        inst_latch_out, rf_we_out, dmem_we_out, retire_out, halted_out;
  logic [2:0]  state_out;

  cpu_sequencer #(.IMEM_LATENCY(2), .DMEM_LATENCY(2), .PC_RESET(32'h0)) dut (
    .clk_100mhz(clk_100mhz), .rst_n_in(rst_n_in), .run_in(run_in),
    .step_in(step_in), .halt_in(halt_in), .is_load_in(is_load_in),
    .is_store_in(is_store_in), .wb_en_in(wb_en_in), .next_pc_in(next_pc_in),
    .pc_out(pc_out), .inst_latch_out(inst_latch_out), .rf_we_out(rf_we_out),
    .dmem_we_out(dmem_we_out), .state_out(state_out), .retire_out(retire_out),
    .halted_out(halted_out), .cycle_count_out(cycle_count_out),
    .instret_out(instret_out)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic        rf;
    int unsigned lat;
    int unsigned nwe;
    logic [31:0] instret;
    logic [31:0] cyc;
    logic        idle;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  bit post_pending = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] npc, input logic rf,
                      input int unsigned lat, input int unsigned nwe,
                      input logic [31:0] instret, input logic [31:0] cyc, input logic idle);
    exp_t e;
    e.pc = pc; e.npc = npc; e.rf = rf; e.lat = lat; e.nwe = nwe;
    e.instret = instret; e.cyc = cyc; e.idle = idle;
    q.push_back(e);
  endtask

  task automatic wait_retire();
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk_100mhz);
      if (retire_out) seen = 1;
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL retire_timeout: got no retire expected retire within 60 cycles");
    end
    @(posedge clk_100mhz); #1;
  endtask

  // Monitor: tracks FETCH entry, counts store strobes, checks each retirement.
  initial begin
    int unsigned cyc = 0, start = 0, nwe = 0;
    logic [2:0] prev = 3'd0;
    exp_t cur;
    forever begin
      @(negedge clk_100mhz);
      cyc++;
      if (!rst_n_in) begin
        post_pending = 0;
      end else begin
        if (post_pending) begin
          check("post_pc", pc_out, cur.npc);
          check("post_instret", instret_out, cur.instret);
          check("post_cycles", cycle_count_out, cur.cyc);
          check("post_state", 32'(state_out), cur.idle ? 32'd0 : 32'd1);
          post_pending = 0;
        end
        if (state_out == 3'd1 && prev != 3'd1) begin start = cyc; nwe = 0; end
        if (dmem_we_out) nwe++;
        if (rf_we_out && state_out != 3'd5) begin
          n_cmp++; n_err++;
          $display("FAIL rf_we_outside_wb: got 1 in state %0d expected 0", state_out);
        end
        if (retire_out) begin
          if (q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_retire: got retire at pc %h expected none", pc_out);
          end else begin
            cur = q.pop_front();
            check("wb_pc", pc_out, cur.pc);
            check("wb_rf_we", 32'(rf_we_out), 32'(cur.rf));
            check("latency", cyc - start + 1, cur.lat);
            check("dmem_we_cycles", nwe, cur.nwe);
            post_pending = 1;
          end
        end
      end
      prev = state_out;
    end
  end

  initial begin
    bit seen;
    repeat (3) @(posedge clk_100mhz);
    @(negedge clk_100mhz) rst_n_in = 1'b1;
    #1;
    check("rst_pc", pc_out, 32'h0);
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_halted", 32'(halted_out), 32'd1);
    check("rst_cycles", cycle_count_out, 32'd0);
    check("rst_instret", instret_out, 32'd0);

    // Store in flight, reset while the write strobe is high.
    @(posedge clk_100mhz); #1;
    is_store_in = 1'b1; run_in = 1'b1;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk_100mhz);
      if (dmem_we_out) seen = 1;
    end
    check("store_we_seen", 32'(seen), 32'd1);
    rst_n_in = 1'b0;
    #1;
    check("abort_dmem_we", 32'(dmem_we_out), 32'd0);
    check("abort_pc", pc_out, 32'h0);
    check("abort_state", 32'(state_out), 32'd0);
    check("abort_halted", 32'(halted_out), 32'd1);
    check("abort_cycles", cycle_count_out, 32'd0);
    check("abort_instret", instret_out, 32'd0);
    check("abort_retire", 32'(retire_out), 32'd0);
    run_in = 1'b0; is_store_in = 1'b0;
    @(negedge clk_100mhz) rst_n_in = 1'b1;
    repeat (10) @(posedge clk_100mhz);
    #1;
    check("idle_hold_state", 32'(state_out), 32'd0);
    check("idle_hold_cycles", cycle_count_out, 32'd0);

    // Three ALU instructions back to back.
    wb_en_in = 1'b1; next_pc_in = 32'h4; run_in = 1'b1;
    push(32'h0, 32'h4, 1'b1, 6, 0, 32'd1, 32'd6, 1'b0);
    wait_retire();
    next_pc_in = 32'h8;
    push(32'h4, 32'h8, 1'b1, 6, 0, 32'd2, 32'd12, 1'b0);
    wait_retire();
    next_pc_in = 32'hC; run_in = 1'b0;
    push(32'h8, 32'hC, 1'b1, 6, 0, 32'd3, 32'd18, 1'b1);
    wait_retire();

    // Load then store.
    is_load_in = 1'b1; next_pc_in = 32'h20; run_in = 1'b1;
    push(32'hC, 32'h20, 1'b1, 9, 0, 32'd4, 32'd27, 1'b0);
    wait_retire();
    is_load_in = 1'b0; is_store_in = 1'b1; wb_en_in = 1'b0;
    next_pc_in = 32'h10; run_in = 1'b0;
    push(32'h20, 32'h10, 1'b0, 7, 1, 32'd5, 32'd34, 1'b1);
    wait_retire();
    is_store_in = 1'b0;

    // Single step; a second step mid-instruction must be ignored.
    wb_en_in = 1'b1; next_pc_in = 32'h14;
    push(32'h10, 32'h14, 1'b1, 6, 0, 32'd6, 32'd40, 1'b1);
    step_in = 1'b1;
    @(posedge clk_100mhz); #1 step_in = 1'b0;
    repeat (2) @(posedge clk_100mhz);
    #1 step_in = 1'b1;
    @(posedge clk_100mhz); #1 step_in = 1'b0;
    wait_retire();
    repeat (10) @(posedge clk_100mhz);
    #1;
    check("step_idle_state", 32'(state_out), 32'd0);
    check("step_idle_pc", pc_out, 32'h14);
    check("step_idle_instret", instret_out, 32'd6);

    // Halt raised during FETCH of a branch; halt beats run afterwards.
    wb_en_in = 1'b0; next_pc_in = 32'h40; run_in = 1'b1;
    push(32'h14, 32'h40, 1'b0, 6, 0, 32'd7, 32'd46, 1'b1);
    @(posedge clk_100mhz); #1 halt_in = 1'b1;
    wait_retire();
    repeat (10) @(posedge clk_100mhz);
    #1;
    check("halt_idle_state", 32'(state_out), 32'd0);
    check("halt_idle_pc", pc_out, 32'h40);
    check("halt_idle_instret", instret_out, 32'd7);

    // Load and store both asserted: load takes priority.
    is_load_in = 1'b1; is_store_in = 1'b1; wb_en_in = 1'b1; next_pc_in = 32'h44;
    push(32'h40, 32'h44, 1'b1, 9, 0, 32'd8, 32'd55, 1'b1);
    halt_in = 1'b0;
    @(posedge clk_100mhz); #1 run_in = 1'b0;
    wait_retire();
    is_load_in = 1'b0; is_store_in = 1'b0;

    // Cycle counter wrap.
    @(posedge clk_100mhz); #1;
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    #1 release dut.cycle_cnt;
    check("wrap_preload", cycle_count_out, 32'hFFFF_FFFE);
    next_pc_in = 32'h48;
    push(32'h44, 32'h48, 1'b1, 6, 0, 32'd9, 32'd4, 1'b1);
    step_in = 1'b1;
    @(posedge clk_100mhz); #1 step_in = 1'b0;
    repeat (3) @(posedge clk_100mhz);
    #1;
    check("wrap_after3", cycle_count_out, 32'h0000_0001);
    wait_retire();

    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_100mhz);
      if (q.size() == 0 && !post_pending) seen = 1;
    end
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
